// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transfer scheduler: i2c_top register map,
// status/control codes, and state encodings.
package i2c_pkg;

  localparam logic [31:0] REG_CR  = 32'h0000_0000;
  localparam logic [31:0] REG_SR  = 32'h0000_0004;
  localparam logic [31:0] REG_TXF = 32'h0000_0008;
  localparam logic [31:0] REG_RXF = 32'h0000_000C;

  localparam int SR_NACK_BIT = 0;
  localparam int SR_BUSY_BIT = 2;

  localparam logic [31:0] CR_EN       = 32'h0000_0001;
  localparam logic [31:0] CR_FLUSH_EN = 32'h0000_0041;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_TXA,
    ST_TXD,
    ST_RLEN,
    ST_POLL,
    ST_RXD,
    ST_ERR,
    ST_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // TX FIFO word: [9]=stop, [8]=start, [7:0]=byte
  function automatic logic [31:0] tx_word(input logic stop, input logic start, input logic [7:0] b);
    return {22'd0, stop, start, b};
  endfunction

endpackage

// File: rtl/i2c_apb_mst.sv
// Two-phase APB master: one transfer per start pulse, done pulses for one
// cycle when the slave accepts the access; read data is held until the next read.
module i2c_apb_mst
  import i2c_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        m_sel_o,
  output logic        m_en_o,
  output logic        m_write_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_rdata_i
);

  apb_state_e  st_q;
  logic        sel_q;
  logic        en_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= APB_IDLE;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        APB_IDLE: begin
          if (start_i) begin
            sel_q   <= 1'b1;
            write_q <= write_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            st_q    <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          en_q <= 1'b1;
          st_q <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (m_ready_i) begin
            sel_q  <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b1;
            if (!write_q) rdata_q <= m_rdata_i;
            st_q   <= APB_IDLE;
          end
        end
        default: st_q <= APB_IDLE;
      endcase
    end
  end

  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign m_sel_o   = sel_q;
  assign m_en_o    = en_q;
  assign m_write_o = write_q;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;

endmodule

// File: rtl/i2c_xfer_sched.sv
// Round-robin I2C transfer scheduler driving i2c_top over APB.
// Optional per-transfer watchdog built in with `define I2C_SCHED_TMO_EN.
module i2c_xfer_sched
  import i2c_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int POLL_GAP = 4,
  parameter int TMO_CYC  = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rnw,
  input  logic [NREQ*7-1:0]    req_addr,
  input  logic [NREQ*3-1:0]    req_len,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic [2:0]           done_id,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 m_sel,
  output logic                 m_en,
  output logic                 m_write,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic                 m_ready,
  input  logic [31:0]          m_rdata
);

  localparam logic [7:0] GAP = 8'(POLL_GAP);

  sched_state_e state_q;
  logic [2:0]      rr_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            done_q;
  logic [2:0]      done_id_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            err_flag_q;

  logic [2:0]  cur_id_q;
  logic        cur_rnw_q;
  logic [6:0]  cur_addr_q;
  logic [2:0]  cur_len_q;
  logic [31:0] cur_wdata_q;
  logic [1:0]  idx_q;
  logic [7:0]  gap_q;

  logic        pend_q;
  logic        start_q;
  logic        apb_write_q;
  logic [31:0] apb_addr_q;
  logic [31:0] apb_wdata_q;
  logic        apb_done;
  logic [31:0] apb_rdata;

  logic        win_vld_d;
  logic [2:0]  win_id_d;
  logic [2:0]  win_len_d;
  logic [2:0]  rr_d;
  logic        len_bad;
  logic        last_w;
  logic        tmo_w;

  i2c_apb_mst u_apb (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_q),
    .write_i   (apb_write_q),
    .addr_i    (apb_addr_q),
    .wdata_i   (apb_wdata_q),
    .done_o    (apb_done),
    .rdata_o   (apb_rdata),
    .m_sel_o   (m_sel),
    .m_en_o    (m_en),
    .m_write_o (m_write),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_ready_i (m_ready),
    .m_rdata_i (m_rdata)
  );

  // Scanning downward leaves the closest set bit at or after rr_q as winner.
  always_comb begin
    int j;
    j         = 0;
    win_vld_d = 1'b0;
    win_id_d  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win_vld_d = 1'b1;
        win_id_d  = 3'(j);
      end
    end
  end

  assign win_len_d = req_len[int'(win_id_d)*3 +: 3];
  assign rr_d      = (int'(win_id_d) == NREQ - 1) ? 3'd0 : win_id_d + 3'd1;
  assign len_bad   = (win_len_d == 3'd0) || (win_len_d > 3'd4);
  assign last_w    = ({1'b0, idx_q} == (cur_len_q - 3'd1));

`ifdef I2C_SCHED_TMO_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_IDLE && win_vld_d) begin
      tmo_cnt_q <= TMO_LIM;
    end else if (busy_q && tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - 16'd1;
    end
  end

  assign tmo_w = busy_q && (tmo_cnt_q == '0);
`else
  // Watchdog limit is only consumed when the watchdog is built in.
  localparam logic [15:0] TMO_UNUSED = 16'(TMO_CYC);
  assign tmo_w = 1'b0;
`endif

  task automatic apb_issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    start_q     <= 1'b1;
    pend_q      <= 1'b1;
    apb_write_q <= wr;
    apb_addr_q  <= a;
    apb_wdata_q <= d;
  endtask

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      err_flag_q  <= 1'b0;
      cur_id_q    <= '0;
      cur_rnw_q   <= 1'b0;
      cur_addr_q  <= '0;
      cur_len_q   <= '0;
      cur_wdata_q <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
      apb_write_q <= 1'b0;
      apb_addr_q  <= '0;
      apb_wdata_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 8'd1;

      // A watchdog hit waits for any APB access in flight before flushing.
      if (tmo_w && !pend_q && state_q != ST_ERR && state_q != ST_DONE) begin
        err_flag_q <= 1'b1;
        state_q    <= ST_ERR;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (win_vld_d) begin
              gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << win_id_d;
              busy_q      <= 1'b1;
              rr_q        <= rr_d;
              cur_id_q    <= win_id_d;
              cur_rnw_q   <= req_rnw[win_id_d];
              cur_addr_q  <= req_addr[int'(win_id_d)*7 +: 7];
              cur_len_q   <= win_len_d;
              cur_wdata_q <= req_wdata[int'(win_id_d)*32 +: 32];
              rdata_q     <= '0;
              idx_q       <= '0;
              gap_q       <= '0;
              pend_q      <= 1'b0;
              err_flag_q  <= len_bad;
              state_q     <= len_bad ? ST_DONE : ST_CFG;
            end
          end
          ST_CFG: begin
            if (!pend_q) apb_issue(1'b1, REG_CR, CR_EN);
            else if (apb_done) begin
              pend_q  <= 1'b0;
              state_q <= ST_TXA;
            end
          end
          ST_TXA: begin
            if (!pend_q) apb_issue(1'b1, REG_TXF, tx_word(1'b0, 1'b1, {cur_addr_q, cur_rnw_q}));
            else if (apb_done) begin
              pend_q  <= 1'b0;
              state_q <= cur_rnw_q ? ST_RLEN : ST_TXD;
            end
          end
          ST_TXD: begin
            if (!pend_q) apb_issue(1'b1, REG_TXF, tx_word(last_w, 1'b0, cur_wdata_q[{idx_q, 3'b000} +: 8]));
            else if (apb_done) begin
              pend_q <= 1'b0;
              if (last_w) state_q <= ST_POLL;
              else        idx_q   <= idx_q + 2'd1;
            end
          end
          ST_RLEN: begin
            if (!pend_q) apb_issue(1'b1, REG_TXF, tx_word(1'b1, 1'b0, {5'd0, cur_len_q}));
            else if (apb_done) begin
              pend_q  <= 1'b0;
              state_q <= ST_POLL;
            end
          end
          ST_POLL: begin
            if (!pend_q) begin
              if (gap_q == '0) apb_issue(1'b0, REG_SR, 32'd0);
            end else if (apb_done) begin
              pend_q <= 1'b0;
              if (apb_rdata[SR_NACK_BIT]) begin
                err_flag_q <= 1'b1;
                state_q    <= ST_ERR;
              end else if (!apb_rdata[SR_BUSY_BIT]) begin
                idx_q   <= '0;
                state_q <= cur_rnw_q ? ST_RXD : ST_DONE;
              end else begin
                gap_q <= GAP;
              end
            end
          end
          ST_RXD: begin
            if (!pend_q) apb_issue(1'b0, REG_RXF, 32'd0);
            else if (apb_done) begin
              pend_q <= 1'b0;
              rdata_q[{idx_q, 3'b000} +: 8] <= apb_rdata[7:0];
              if (last_w) state_q <= ST_DONE;
              else        idx_q   <= idx_q + 2'd1;
            end
          end
          ST_ERR: begin
            if (!pend_q) apb_issue(1'b1, REG_CR, CR_FLUSH_EN);
            else if (apb_done) begin
              pend_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            done_q    <= 1'b1;
            err_q     <= err_flag_q;
            done_id_q <= cur_id_q;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Only status bits and the low data byte are consumed from read data.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^{apb_rdata[31:8], 1'b0};

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Directed bench for i2c_xfer_sched with a behavioural i2c_top APB slave.
module tb_i2c_xfer_sched;

  localparam int NREQ = 2;
`ifdef I2C_SCHED_TMO_EN
  localparam int TMO = 300;
`else
  localparam int TMO = 65535;
`endif

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_rnw = '0;
  logic [NREQ*7-1:0]   req_addr = '0;
  logic [NREQ*3-1:0]   req_len = '0;
  logic [NREQ*32-1:0]  req_wdata = '0;
  logic [NREQ-1:0]     gnt;
  logic                done;
  logic [2:0]          done_id;
  logic                err;
  logic [31:0]         rdata;
  logic                busy;
  logic                m_sel, m_en, m_write;
  logic [31:0]         m_addr, m_wdata;
  logic                m_ready = 1'b1;
  logic [31:0]         m_rdata = '0;

  always #5 clk = ~clk;

  i2c_xfer_sched #(.NREQ(NREQ), .POLL_GAP(4), .TMO_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .done(done), .done_id(done_id),
    .err(err), .rdata(rdata), .busy(busy), .m_sel(m_sel), .m_en(m_en), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // i2c_top model: logs writes, answers SR and RX_FIFO reads
  int          sr_busy_left = 0;
  bit          sr_nack = 0;
  int          sr_reads = 0;
  int          sel_cycles = 0;
  int          onehot_bad = 0;
  logic [31:0] rx_q[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          gnt_order[$];
  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (m_sel) sel_cycles++;
    if (gnt != '0 && !$onehot(gnt)) onehot_bad++;
    if (gnt != '0 && prev_gnt == '0) gnt_order.push_back(gnt[1] ? 1 : 0);
    prev_gnt = gnt;
    if (m_sel && m_en && m_ready) begin
      if (m_write) begin
        wr_a.push_back(m_addr);
        wr_d.push_back(m_wdata);
      end else if (m_addr == 32'h4) begin
        sr_reads++;
        if (sr_nack) m_rdata = 32'h1;
        else if (sr_busy_left > 0) begin
          m_rdata = 32'h4;
          sr_busy_left--;
        end else m_rdata = 32'h0;
      end else if (m_addr == 32'hC) begin
        if (rx_q.size() > 0) m_rdata = rx_q.pop_front();
        else m_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  logic [31:0] ea[$];
  logic [31:0] ed[$];
  logic [2:0]  d_id;
  logic        d_err;
  logic [31:0] d_rdata;
  int          d_cyc;

  task automatic set_req(input int id, input logic rnw, input logic [6:0] a,
                         input logic [2:0] len, input logic [31:0] wd);
    req_rnw[id]           = rnw;
    req_addr[id*7 +: 7]   = a;
    req_len[id*3 +: 3]    = len;
    req_wdata[id*32 +: 32] = wd;
  endtask

  task automatic clr_log();
    wr_a.delete();
    wr_d.delete();
    sr_reads = 0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit drop);
    bit seen;
    seen  = 0;
    d_cyc = 0;
    while (!seen && d_cyc < max_cyc) begin
      @(posedge clk); #1;
      d_cyc++;
      if (done) begin
        seen    = 1;
        d_id    = done_id;
        d_err   = err;
        d_rdata = rdata;
        if (drop) req = '0;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_wr(input string tag);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++) begin
      if (i < wr_a.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), wr_a[i], ea[i]);
        chk($sformatf("%s_wd%0d", tag, i), wr_d[i], ed[i]);
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit found;
    int s0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ctrl", {25'd0, busy, done, err, m_sel, m_en, m_write, 1'b0}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: write len=2
    set_req(0, 1'b0, 7'h50, 3'd2, 32'h0000_BEEF);
    clr_log();
    sr_busy_left = 2;
    req = 2'b01;
    wait_done("t1", 400, 1);
    chk("t1_id", 32'(d_id), 32'd0);
    chk("t1_err", 32'(d_err), 32'd0);
    chk("t1_rdata", d_rdata, 32'd0);
    ea = '{32'h0, 32'h8, 32'h8, 32'h8};
    ed = '{32'h001, 32'h1A0, 32'h0EF, 32'h2BE};
    chk_wr("t1");
    chk("t1_polls", 32'(sr_reads), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: read len=3
    set_req(1, 1'b1, 7'h21, 3'd3, 32'h0);
    clr_log();
    rx_q = '{32'h11, 32'h22, 32'h33};
    sr_busy_left = 1;
    req = 2'b10;
    wait_done("t2", 400, 1);
    chk("t2_id", 32'(d_id), 32'd1);
    chk("t2_err", 32'(d_err), 32'd0);
    chk("t2_rdata", d_rdata, 32'h0033_2211);
    ea = '{32'h0, 32'h8, 32'h8};
    ed = '{32'h001, 32'h143, 32'h203};
    chk_wr("t2");
    chk("t2_rx_left", 32'(rx_q.size()), 32'd0);

    // 3: both held, round robin
    set_req(0, 1'b0, 7'h10, 3'd1, 32'hA5);
    set_req(1, 1'b0, 7'h11, 3'd1, 32'h5A);
    clr_log();
    sr_busy_left = 0;
    gnt_order.delete();
    onehot_bad = 0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done($sformatf("t3_%0d", i), 400, i == 3);
      chk($sformatf("t3_id%0d", i), 32'(d_id), 32'(i % 2));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t3_ngrants", 32'(gnt_order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_order.size()) chk($sformatf("t3_order%0d", i), 32'(gnt_order[i]), 32'(i % 2));
    chk("t3_onehot", 32'(onehot_bad), 32'd0);

    // 4: NACK -> flush, then normal service
    set_req(0, 1'b0, 7'h30, 3'd1, 32'h77);
    clr_log();
    sr_nack = 1;
    req = 2'b01;
    wait_done("t4", 400, 1);
    chk("t4_id", 32'(d_id), 32'd0);
    chk("t4_err", 32'(d_err), 32'd1);
    ea = '{32'h0, 32'h8, 32'h8, 32'h0};
    ed = '{32'h001, 32'h160, 32'h277, 32'h041};
    chk_wr("t4");
    sr_nack = 0;
    set_req(1, 1'b0, 7'h31, 3'd1, 32'h01);
    clr_log();
    req = 2'b10;
    wait_done("t4b", 400, 1);
    chk("t4b_id", 32'(d_id), 32'd1);
    chk("t4b_err", 32'(d_err), 32'd0);
    chk("t4b_nwr", 32'(wr_a.size()), 32'd3);

    // 5: len=0 rejected without bus traffic
    set_req(0, 1'b0, 7'h40, 3'd0, 32'h0);
    clr_log();
    @(posedge clk); #1;
    s0 = sel_cycles;
    req = 2'b01;
    wait_done("t5", 10, 1);
    chk("t5_err", 32'(d_err), 32'd1);
    chk("t5_id", 32'(d_id), 32'd0);
    chk("t5_lat_le3", 32'(d_cyc <= 3), 32'd1);
    @(posedge clk); #1;
    chk("t5_sel_cycles", 32'(sel_cycles - s0), 32'd0);

    // 6: reset during a stalled RX_FIFO read
    set_req(1, 1'b1, 7'h22, 3'd2, 32'h0);
    clr_log();
    rx_q = '{32'hAA, 32'hBB};
    req = 2'b10;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (m_sel && !m_write && m_addr == 32'hC) begin
        m_ready = 1'b0;
        found = 1;
      end
    end
    chk("t6_rxd_reached", 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stalled", {30'd0, m_sel, m_en}, 32'h3);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t6_ctrl", {21'd0, gnt, busy, done, err, m_sel, m_en, m_write, done_id}, 32'd0);
    chk("t6_addr", m_addr, 32'd0);
    chk("t6_wdata", m_wdata, 32'd0);
    chk("t6_rdata", rdata, 32'd0);
    req = '0;
    m_ready = 1'b1;
    rx_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

`ifdef I2C_SCHED_TMO_EN
    // watchdog: SR never reports idle
    set_req(0, 1'b0, 7'h12, 3'd1, 32'h3C);
    clr_log();
    sr_busy_left = 1_000_000;
    req = 2'b01;
    wait_done("t7", TMO + 100, 1);
    chk("t7_err", 32'(d_err), 32'd1);
    chk("t7_lat_window", 32'(d_cyc >= TMO && d_cyc <= TMO + 30), 32'd1);
    if (wr_d.size() > 0) chk("t7_flush", wr_d[wr_d.size()-1], 32'h041);
    sr_busy_left = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
